// File: rtl/face_result_tx_sched.sv
// Queues VJ face detections and end-of-frame markers, then serialises each as a
// 5-byte packet onto the shared UART transmitter, one byte per tx_start pulse.
module face_result_tx_sched #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned COORD_W    = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        face_valid,
  input  logic [COORD_W-1:0]          face_row,
  input  logic [COORD_W-1:0]          face_col,
  input  logic [COORD_W-1:0]          face_size,
  input  logic                        frame_done,
  input  logic                        tx_busy,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  drop_count
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned PKT_BYTES = 5;

  typedef struct packed {
    logic               is_eof;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] size;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } state_t;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               eof_pending;
  logic [7:0]         pkt_b [PKT_BYTES];
  logic [IDX_W-1:0]   idx;
  state_t             state;

  state_t             state_n;
  logic [IDX_W-1:0]   idx_n;
  logic               tx_start_n;
  logic [7:0]         tx_data_n;
  logic [CNT_W-1:0]   count_n;
  logic [7:0]         cur_byte;
  logic               face_push_c;
  logic               face_drop_c;
  logic               eof_push_c;
  logic               push_c;
  logic               pop_c;
  entry_t             push_entry;
  entry_t             head;

  // Window end coordinate, saturated; a zero-size window ends where it starts.
  function automatic logic [COORD_W-1:0] win_end(input logic [COORD_W-1:0] start,
                                                  input logic [COORD_W-1:0] size);
    logic [COORD_W:0] sum;
    sum = {1'b0, start} + {1'b0, size} - (COORD_W+1)'(1);
    if (size == '0)
      win_end = start;
    else if (sum[COORD_W])
      win_end = '1;
    else
      win_end = sum[COORD_W-1:0];
  endfunction

  // Faces leave the last slot free so an EOF can always be queued.
  always_comb begin
    face_push_c = face_valid && (fifo_count < CNT_W'(FIFO_DEPTH - 1));
    face_drop_c = face_valid && !face_push_c;
    eof_push_c  = !face_valid && eof_pending && (fifo_count < CNT_W'(FIFO_DEPTH));
    push_c      = face_push_c || eof_push_c;
    push_entry  = '0;
    if (eof_push_c) begin
      push_entry.is_eof = 1'b1;
    end else begin
      push_entry.row  = face_row;
      push_entry.col  = face_col;
      push_entry.size = face_size;
    end
    head = mem[rd_ptr];
  end

  always_comb begin
    count_n = fifo_count;
    if (push_c && !pop_c)
      count_n = fifo_count + CNT_W'(1);
    else if (!push_c && pop_c)
      count_n = fifo_count - CNT_W'(1);
  end

  always_comb begin
    case (idx)
      3'd0:    cur_byte = pkt_b[0];
      3'd1:    cur_byte = pkt_b[1];
      3'd2:    cur_byte = pkt_b[2];
      3'd3:    cur_byte = pkt_b[3];
      default: cur_byte = pkt_b[4];
    endcase
  end

  // Queue storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push_c)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      eof_pending <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (push_c)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)
        rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count  <= count_n;
      eof_pending <= (eof_pending && !eof_push_c) || frame_done;
      if (face_drop_c && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PKT_BYTES; i++)
        pkt_b[i] <= '0;
    end else if (pop_c) begin
      if (head.is_eof) begin
        for (int unsigned i = 0; i < PKT_BYTES; i++)
          pkt_b[i] <= '0;
      end else begin
        pkt_b[0] <= 8'h01;
        pkt_b[1] <= 8'(head.col);
        pkt_b[2] <= 8'(head.row);
        pkt_b[3] <= 8'(win_end(head.col, head.size));
        pkt_b[4] <= 8'(win_end(head.row, head.size));
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      busy     <= (state_n != IDLE) || (count_n != '0);
    end
  end

  // GUARD covers the cycle before the transmitter reflects the new byte in tx_busy.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;
    pop_c      = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop_c   = 1'b1;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = cur_byte;
          state_n    = GUARD;
        end
      end
      GUARD: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          if (idx == IDX_W'(PKT_BYTES - 1)) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
